// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with per-grant hold limit and timeout pulse.
// The registered grant index/valid feed a 2-to-4 decoder that produces the one-hot grant.

module dec2to4 (
    input  logic [1:0] a,
    input  logic       en,
    output logic [0:3] y
);
    always_comb begin
        y = '0;
        if (en) y[a] = 1'b1;
    end
endmodule

// state | meaning
// IDLE  | no grant active; pick next requester in rotation from ptr
// GRANT | gnt_id owns the resource; watch release and hold limit
module arb4_rr #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [3:0]     req,
    output logic [0:3]     gnt,
    output logic [1:0]     gnt_id,
    output logic           gnt_vld,
    output logic           tmo
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [1:0]       gnt_id_nxt;
    logic             gnt_vld_nxt;
    logic             tmo_nxt;
    logic [1:0]       pick_id;
    logic             pick_ok;

    // Walk from the farthest candidate to ptr so the nearest set bit wins.
    always_comb begin
        pick_ok = 1'b0;
        pick_id = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                pick_ok = 1'b1;
                pick_id = ptr + 2'(k);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        gnt_id_nxt   = gnt_id;
        gnt_vld_nxt  = gnt_vld;
        tmo_nxt      = 1'b0;
        case (state)
            IDLE: begin
                gnt_vld_nxt = 1'b0;
                if (en && pick_ok) begin
                    gnt_id_nxt   = pick_id;
                    gnt_vld_nxt  = 1'b1;
                    hold_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                if (!en || !req[gnt_id] || hold_cnt == HOLD_LAST) begin
                    tmo_nxt      = en && req[gnt_id];
                    gnt_vld_nxt  = 1'b0;
                    ptr_nxt      = gnt_id + 2'd1;
                    hold_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            gnt_id   <= gnt_id_nxt;
            gnt_vld  <= gnt_vld_nxt;
            tmo      <= tmo_nxt;
        end
    end

    dec2to4 u_dec (
        .a  (gnt_id),
        .en (gnt_vld),
        .y  (gnt)
    );
endmodule

// File: doc/arb4_rr.md
# arb4_rr

Four-requester round-robin arbiter with grant hold and timeout, sharing one resource addressed by a 2-bit select. The registered grant index and valid drive a `dec2to4` instance (`a` = `gnt_id`, `en` = `gnt_vld`), which produces the one-hot grant vector `gnt`. The block sits between up to four client engines and a shared single-port resource, such as a bus or register bank, and guarantees starvation-free, mutually exclusive access.

## Interface
- `MAX_HOLD`, 8: maximum consecutive grant cycles per grant. Legal range 1..15.
- `CNT_W`, 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

- `clk`  in  1: single clock, all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: arbiter enable. 0 blocks new grants and releases any current grant.
- `req`  in  4: request vector. `req[i]` is held high by client i for as long as it wants access.
- `gnt`  out  [0:3]: one-hot grant. Output of `dec2to4`, all-zero when `gnt_vld`=0.
- `gnt_id`  out  2: index of the granted client. Registered.
- `gnt_vld`  out  1: a grant is active. Registered.
- `tmo`  out  1: one-cycle pulse when a grant is force-released by timeout. Registered.

## Operation
- Reset values: state IDLE, `gnt_id`=0, `gnt_vld`=0, `gnt`=0000, `tmo`=0, `ptr`=0, `hold_cnt`=0.
- `ptr` (2 bits) is the highest-priority candidate. Search order is `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, all modulo 4 (wrap 3→0).

**IDLE**
- Condition: `en`=1 and `req`≠0.
- Action: select the first set bit of `req` in search order; load `gnt_id`, set `gnt_vld`=1, clear `hold_cnt`; next state GRANT.
- Otherwise stay in IDLE with `gnt_vld`=0.

**GRANT**
- Each cycle, evaluate release conditions in this priority order:
  1. `en`=0 or `req[gnt_id]`=0 → normal release.
  2. `hold_cnt`=MAX_HOLD−1 → timeout release; `tmo`=1 for one cycle.
  3. Otherwise `hold_cnt`+1 and hold the grant.
- On any release: `gnt_vld`←0, `ptr`←`gnt_id`+1 mod 4, `hold_cnt`←0, next state IDLE.
- After release, `gnt_id` keeps its last value. Only `gnt_vld` qualifies it.

**Rules**
- Requests from other clients during GRANT are ignored until the next IDLE evaluation.
- A client that timed out and still holds `req` is re-granted only in rotation order. If it is the sole requester, it is re-granted after the one idle cycle.
- `rst` overrides everything, including mid-grant. Outputs return to reset values on the next edge, with no `tmo` pulse.
- `gnt` is combinational from registered `gnt_id`/`gnt_vld` through `dec2to4`, so it is glitch-free relative to `clk`.

## Timing
- Request to grant: `req` sampled high at edge N in IDLE → `gnt_vld`/`gnt` high after edge N.
- Release: `req[gnt_id]` sampled low at edge N → `gnt_vld` low after edge N.
- Minimum one idle cycle between consecutive grants, so handover costs 2 cycles.
- Maximum grant length is exactly MAX_HOLD cycles with `gnt_vld`=1.
- `tmo` is high in the first IDLE cycle after a timeout release and low otherwise.
- Worst-case wait for a continuously requesting client: 3·(MAX_HOLD+1) cycles from entering the rotation.

## Test plan
- **Reset / idle:** `rst`=1 for 2 cycles with `req`=1111 → `gnt`=0000, `gnt_vld`=0, `tmo`=0. Release `rst`, `en`=0 → still no grant.
- **Single request:** `en`=1, `req`=0100 for 3 cycles then 0000 → `gnt_id`=2 and `gnt`=0010 (index order [0:3]) for 3 cycles starting the cycle after `req` rises. `gnt_vld` drops one cycle after `req` falls. `ptr`=3.
- **Rotation:** `req`=1111 held and released per grant after 2 cycles each → grant order 0,1,2,3,0, with one idle cycle between grants. Wrap from 3 to 0 is verified.
- **Timeout:** `MAX_HOLD`=8, `req`=0001 held constant → `gnt_vld` high for exactly 8 cycles, `tmo` pulses once, 1 idle cycle, then client 0 is re-granted. With `req`=0011 the second grant goes to client 1.
- **Enable / reset mid-grant:** grant active to client 3, drop `en` → `gnt_vld`=0 next cycle, `ptr`=0, no `tmo`. Repeat with `rst` pulse → all outputs at reset values and `ptr`=0.
